// File: rtl/machine_timer.sv
// machine_timer: RISC-V machine timer with a 64-bit mtime counter, a programmable
// prescaler, a 64-bit mtimecmp compare register and optional periodic reload.
// The FSM state is visible through the STATUS register (index 6, bits[2:1]).
//
// Register port handshake: there is no valid/ready pair. A write is accepted
// on every rising clock edge where wr_en is high, one write per cycle, and
// takes effect at that edge. A read is purely combinational on rd_addr and
// returns the registered values, so the result of a write becomes visible in
// the following cycle (no write forwarding).
module machine_timer #(
  parameter int X_LEN      = 32,
  parameter int PRESCALE_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [X_LEN-1:0] wr_data,
  input  logic [2:0]       rd_addr,
  output logic [X_LEN-1:0] rd_data,
  input  logic             irq_ack,
  output logic             timer_timeout
);

  // Register indices
  localparam logic [2:0] A_MTIME_LO    = 3'd0;
  localparam logic [2:0] A_MTIME_HI    = 3'd1;
  localparam logic [2:0] A_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] A_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] A_CTRL        = 3'd4;
  localparam logic [2:0] A_PERIOD      = 3'd5;
  localparam logic [2:0] A_STATUS      = 3'd6;

  typedef enum logic [1:0] {
    ST_ARMED = 2'd0,
    ST_FIRED = 2'd1,
    ST_ACKED = 2'd2
  } state_t;

  // Architectural state
  logic [63:0]           r_mtime;
  logic [63:0]           r_mtimecmp;
  logic                  r_en;
  logic                  r_periodic;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [31:0]           r_period;
  logic [PRESCALE_W-1:0] r_presc_cnt;
  state_t                r_state;
  state_t                w_state_next;

  // Decoded strobes and datapath helpers
  logic        w_run;
  logic        w_tick;
  logic        w_match;
  logic        w_wr_mtime_lo;
  logic        w_wr_mtime_hi;
  logic        w_wr_cmp_lo;
  logic        w_wr_cmp_hi;
  logic        w_wr_cmp;
  logic        w_wr_ctrl;
  logic        w_wr_period;
  logic        w_reload;
  logic [63:0] w_mtime_inc;
  logic [63:0] w_cmp_reload;
  logic [31:0] w_wdata32;

  assign w_wdata32     = wr_data[31:0];
  assign w_run         = r_en && enable;
  assign w_tick        = w_run && (r_presc_cnt == r_prescale);
  assign w_match       = r_en && (r_mtime >= r_mtimecmp);

  assign w_wr_mtime_lo = wr_en && (wr_addr == A_MTIME_LO);
  assign w_wr_mtime_hi = wr_en && (wr_addr == A_MTIME_HI);
  assign w_wr_cmp_lo   = wr_en && (wr_addr == A_MTIMECMP_LO);
  assign w_wr_cmp_hi   = wr_en && (wr_addr == A_MTIMECMP_HI);
  assign w_wr_cmp      = w_wr_cmp_lo || w_wr_cmp_hi;
  assign w_wr_ctrl     = wr_en && (wr_addr == A_CTRL);
  assign w_wr_period   = wr_en && (wr_addr == A_PERIOD);

  // Auto-reload only when acknowledging a fired periodic timer and software
  // is not simultaneously writing mtimecmp (the explicit write wins).
  assign w_reload      = (r_state == ST_FIRED) && irq_ack && r_periodic && !w_wr_cmp;

  assign w_mtime_inc   = r_mtime + 64'd1;
  assign w_cmp_reload  = r_mtimecmp + {32'd0, r_period};

  assign timer_timeout = (r_state == ST_FIRED);

  // Prescaler: counts while running, clears on terminal count, stop or CTRL write
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc_cnt <= '0;
    end else if (w_wr_ctrl || !w_run || w_tick) begin
      r_presc_cnt <= '0;
    end else begin
      r_presc_cnt <= r_presc_cnt + 1'b1;
    end
  end

  // mtime: a software write to either half drops that cycle's tick entirely
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mtime <= '0;
    end else if (w_wr_mtime_lo) begin
      r_mtime[31:0] <= w_wdata32;
    end else if (w_wr_mtime_hi) begin
      r_mtime[63:32] <= w_wdata32;
    end else if (w_tick) begin
      r_mtime <= w_mtime_inc;
    end
  end

  // mtimecmp: software writes take priority over the periodic reload
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mtimecmp <= '1;
    end else if (w_wr_cmp_lo) begin
      r_mtimecmp[31:0] <= w_wdata32;
    end else if (w_wr_cmp_hi) begin
      r_mtimecmp[63:32] <= w_wdata32;
    end else if (w_reload) begin
      r_mtimecmp <= w_cmp_reload;
    end
  end

  // CTRL and PERIOD registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_en       <= 1'b0;
      r_periodic <= 1'b0;
      r_prescale <= '0;
      r_period   <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_en       <= wr_data[0];
        r_periodic <= wr_data[1];
        r_prescale <= wr_data[8 +: PRESCALE_W];
      end
      if (w_wr_period) begin
        r_period <= w_wdata32;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_ARMED;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state; the unused encoding behaves as ARMED
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_FIRED: begin
        if (w_wr_cmp) begin
          w_state_next = ST_ARMED;
        end else if (irq_ack) begin
          w_state_next = r_periodic ? ST_ARMED : ST_ACKED;
        end
      end
      ST_ACKED: begin
        if (w_wr_cmp) begin
          w_state_next = ST_ARMED;
        end
      end
      default: begin
        w_state_next = w_match ? ST_FIRED : ST_ARMED;
      end
    endcase
  end

  // Combinational register read mux
  always_comb begin
    rd_data = '0;
    case (rd_addr)
      A_MTIME_LO:    rd_data[31:0] = r_mtime[31:0];
      A_MTIME_HI:    rd_data[31:0] = r_mtime[63:32];
      A_MTIMECMP_LO: rd_data[31:0] = r_mtimecmp[31:0];
      A_MTIMECMP_HI: rd_data[31:0] = r_mtimecmp[63:32];
      A_CTRL: begin
        rd_data[0]              = r_en;
        rd_data[1]              = r_periodic;
        rd_data[8 +: PRESCALE_W] = r_prescale;
      end
      A_PERIOD:      rd_data[31:0] = r_period;
      A_STATUS: begin
        rd_data[0]   = timer_timeout;
        rd_data[2:1] = r_state;
      end
      default:       rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_machine_timer.sv
// tb_machine_timer: directed scenarios for machine_timer. Drivers push the
// expected response into a queue; a monitor on the falling edge pops and
// compares every pending entry against the DUT outputs.
module tb_machine_timer;

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic        enable  = 1'b1;
  logic        wr_en   = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [31:0] wr_data = 32'd0;
  logic [2:0]  rd_addr = 3'd0;
  logic [31:0] rd_data;
  logic        irq_ack = 1'b0;
  logic        timer_timeout;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard queues: kind 0 = rd_data compare, kind 1 = timer_timeout compare
  logic [31:0] exp_q[$];
  bit          kind_q[$];
  string       name_q[$];

  machine_timer #(.X_LEN(32), .PRESCALE_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .irq_ack       (irq_ack),
    .timer_timeout (timer_timeout)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  // Monitor: compare every pending expectation mid-cycle
  always @(negedge clk) begin : monitor
    logic [31:0] m_exp;
    bit          m_kind;
    string       m_name;
    while (kind_q.size() > 0) begin
      m_kind = kind_q.pop_front();
      m_exp  = exp_q.pop_front();
      m_name = name_q.pop_front();
      n_checks++;
      if (m_kind == 1'b0) begin
        if (rd_data !== m_exp) begin
          n_errors++;
          $display("FAIL %s: rd_data=0x%08h expected 0x%08h (t=%0t)", m_name, rd_data, m_exp, $time);
        end
      end else begin
        if (timer_timeout !== m_exp[0]) begin
          n_errors++;
          $display("FAIL %s: timer_timeout=%0b expected %0b (t=%0t)", m_name, timer_timeout, m_exp[0], $time);
        end
      end
    end
  end

  // Driver tasks: all inputs change 1ns after the rising edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step(1);
    wr_en   = 1'b0;
  endtask

  task automatic exp_to(input bit v, input string nm);
    kind_q.push_back(1'b1);
    exp_q.push_back({31'd0, v});
    name_q.push_back(nm);
  endtask

  task automatic exp_rd(input logic [2:0] a, input logic [31:0] v, input string nm);
    rd_addr = a;
    kind_q.push_back(1'b0);
    exp_q.push_back(v);
    name_q.push_back(nm);
    step(1);
  endtask

  initial begin
    // Reset and idle
    step(2);
    reset = 1'b0;
    exp_rd(3'd2, 32'hFFFF_FFFF, "rst_cmp_lo");
    exp_rd(3'd3, 32'hFFFF_FFFF, "rst_cmp_hi");
    exp_rd(3'd6, 32'h0, "rst_status");
    for (int i = 0; i < 1000; i++) begin
      exp_to(1'b0, "rst_idle_to");
      step(1);
    end

    // One-shot, prescale 0: fires the cycle after mtime reaches 10
    wr(3'd2, 32'd10);
    wr(3'd3, 32'd0);
    wr(3'd4, 32'h1);
    for (int i = 0; i <= 11; i++) begin
      exp_to(i >= 11, "os_to");
      exp_rd(3'd0, 32'(i), "os_mtime");
    end
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    exp_to(1'b0, "os_ack_to");
    exp_rd(3'd6, 32'h4, "os_acked_status");
    wr(3'd2, 32'd30);
    exp_rd(3'd6, 32'h0, "os_rearm_status");
    for (int i = 16; i <= 31; i++) begin
      exp_to(i >= 31, "os2_to");
      exp_rd(3'd0, 32'(i), "os2_mtime");
    end
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    wr(3'd4, 32'h0);

    // Prescale 3: one tick every 4 cycles, enable gating resets the prescaler
    wr(3'd0, 32'd0);
    wr(3'd1, 32'd0);
    wr(3'd3, 32'd1);
    wr(3'd4, 32'h301);
    for (int i = 0; i <= 13; i++) exp_rd(3'd0, 32'(i / 4), "ps_mtime");
    enable = 1'b0;
    for (int i = 0; i < 10; i++) exp_rd(3'd0, 32'd3, "ps_hold_mtime");
    exp_rd(3'd4, 32'h301, "ps_ctrl");
    enable = 1'b1;
    for (int i = 0; i <= 8; i++) exp_rd(3'd0, 32'(3 + i / 4), "ps_resume_mtime");

    // Periodic: PERIOD 100, mtimecmp 50
    wr(3'd4, 32'h0);
    wr(3'd0, 32'd0);
    wr(3'd1, 32'd0);
    wr(3'd5, 32'd100);
    wr(3'd2, 32'd50);
    wr(3'd3, 32'd0);
    wr(3'd4, 32'h3);
    for (int i = 0; i <= 51; i++) begin
      exp_to(i >= 51, "per_to");
      exp_rd(3'd0, 32'(i), "per_mtime");
    end
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    exp_to(1'b0, "per_ack_to");
    exp_rd(3'd2, 32'd150, "per_reload_lo");
    exp_rd(3'd3, 32'd0, "per_reload_hi");
    exp_rd(3'd6, 32'h0, "per_armed_status");
    for (int i = 56; i <= 151; i++) begin
      exp_to(i >= 151, "per2_to");
      exp_rd(3'd0, 32'(i), "per2_mtime");
    end

    // irq_ack together with an mtimecmp write: the write wins, no reload
    irq_ack = 1'b1;
    wr(3'd2, 32'd500);
    irq_ack = 1'b0;
    exp_to(1'b0, "sim_to");
    exp_rd(3'd2, 32'd500, "sim_cmp_lo");
    exp_rd(3'd6, 32'h0, "sim_status");

    // Wrap and carry, single ticks via a one-cycle enable pulse
    enable = 1'b0;
    wr(3'd2, 32'hFFFF_FFFF);
    wr(3'd3, 32'hFFFF_FFFF);
    wr(3'd4, 32'h1);
    wr(3'd0, 32'hFFFF_FFFF);
    wr(3'd1, 32'h0);
    enable = 1'b1;
    step(1);
    enable = 1'b0;
    exp_rd(3'd0, 32'h0, "carry_lo");
    exp_rd(3'd1, 32'h1, "carry_hi");
    wr(3'd0, 32'hFFFF_FFFF);
    wr(3'd1, 32'hFFFF_FFFF);
    enable = 1'b1;
    step(1);
    enable = 1'b0;
    exp_to(1'b1, "wrap_fire_to");
    exp_rd(3'd0, 32'h0, "wrap_lo");
    exp_rd(3'd1, 32'h0, "wrap_hi");
    exp_rd(3'd6, 32'h3, "wrap_status");
    enable = 1'b1;
    wr(3'd0, 32'h1234_5678);
    enable = 1'b0;
    exp_rd(3'd0, 32'h1234_5678, "wr_tick_lo");
    exp_to(1'b1, "pre_rst_to");
    exp_rd(3'd1, 32'h0, "wr_tick_hi");

    // Reset while FIRED
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    exp_to(1'b0, "rst2_to");
    exp_rd(3'd0, 32'h0, "rst2_mtime_lo");
    exp_rd(3'd1, 32'h0, "rst2_mtime_hi");
    exp_rd(3'd2, 32'hFFFF_FFFF, "rst2_cmp_lo");
    exp_rd(3'd3, 32'hFFFF_FFFF, "rst2_cmp_hi");
    exp_rd(3'd4, 32'h0, "rst2_ctrl");
    exp_rd(3'd5, 32'h0, "rst2_period");
    exp_rd(3'd6, 32'h0, "rst2_status");

    // Read-only STATUS and reserved index ignore writes
    wr(3'd6, 32'hFFFF_FFFF);
    wr(3'd7, 32'hFFFF_FFFF);
    exp_rd(3'd6, 32'h0, "ro_status");
    exp_rd(3'd7, 32'h0, "reserved");

    step(2);
    if (kind_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", kind_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
